// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared state encoding, widths and helpers for the keypad scanner
package keypad_pkg;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int ROW_W  = 2;
  localparam int COL_W  = 2;
  localparam int CODE_W = 4;

  typedef enum logic [1:0] {
    ST_SCAN    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_HELD    = 2'd2,
    ST_RELEASE = 2'd3
  } scan_state_e;

  // Stable-count actions requested by the scan FSM
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_CLR  = 2'd1,
    CNT_ONE  = 2'd2,
    CNT_INC  = 2'd3
  } cnt_op_e;

  // Index of the lowest-numbered active-low column (0 when none is low)
  function automatic logic [COL_W-1:0] lowest_low(input logic [COLS-1:0] col_n);
    logic [COL_W-1:0] idx;
    idx = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!col_n[i]) idx = COL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_sync_debounce.sv
// rtl/key_sync_debounce.sv - column synchronizer and stable-sample counter
module key_sync_debounce
  import keypad_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [COLS-1:0]  col_i,
  input  cnt_op_e          cnt_op_i,
  output logic [COLS-1:0]  col_sync_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [COLS-1:0]  meta_q;
  logic [COLS-1:0]  sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Two-flop synchronizer; idle lines are pulled up, so reset to all ones
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= col_i;
      sync_q <= meta_q;
    end
  end

  // Next value of the consecutive-sample counter as directed by the FSM
  always_comb begin
    cnt_d = cnt_q;
    case (cnt_op_i)
      CNT_CLR: cnt_d = '0;
      CNT_ONE: cnt_d = CNT_W'(1);
      CNT_INC: cnt_d = cnt_q + CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign col_sync_o = sync_q;
  assign cnt_o      = cnt_q;

endmodule

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 keypad row scanner with key capture; KEYPAD_DEBOUNCE_EN enables debounce
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [COLS-1:0]   Col_In,
  output logic [ROWS-1:0]   Row_Out,
  output logic [CODE_W-1:0] Key_Code,
  output logic              Key_Valid,
  output logic              Key_Held
);

  // Samples needed to accept or release a key; one sample when debounce is off
`ifdef KEYPAD_DEBOUNCE_EN
  localparam int NEED = DEBOUNCE_SCANS * 4;
`else
  localparam int NEED = 1 + 0 * DEBOUNCE_SCANS;
`endif
  localparam int               CNT_W    = $clog2(NEED + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NEED - 1);
  localparam int               DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0]  div_q;
  logic [ROW_W-1:0]  row_q;
  scan_state_e       state_q,   state_d;
  logic [COL_W-1:0]  lat_col_q, lat_col_d;
  logic [CODE_W-1:0] code_q,    code_d;
  logic              valid_q,   valid_d;
  logic              held_q,    held_d;

  logic              tick;
  logic              row_adv;
  cnt_op_e           cnt_op;
  logic [COLS-1:0]   col_sync;
  logic [COLS-1:0]   col_low;
  logic              any_low;
  logic [COL_W-1:0]  first_col;
  logic [CNT_W-1:0]  cnt_q;

  key_sync_debounce #(
    .CNT_W (CNT_W)
  ) u_sync (
    .clk_i      (CLK),
    .rst_i      (RST),
    .col_i      (Col_In),
    .cnt_op_i   (cnt_op),
    .col_sync_o (col_sync),
    .cnt_o      (cnt_q)
  );

  // Columns are judged in the last dwell cycle, just before the row moves on
  assign tick      = (div_q == DIV_LAST);
  assign col_low   = ~col_sync;
  assign any_low   = |col_low;
  assign first_col = lowest_low(col_sync);

  // Dwell divider: wraps every SCAN_DIV cycles
  always_ff @(posedge CLK) begin
    if (RST)       div_q <= '0;
    else if (tick) div_q <= '0;
    else           div_q <= div_q + DIV_W'(1);
  end

  // Scan FSM next state; the row only advances on ticks that land in SCAN
  always_comb begin
    state_d   = state_q;
    lat_col_d = lat_col_q;
    code_d    = code_q;
    held_d    = held_q;
    valid_d   = 1'b0;
    row_adv   = 1'b0;
    cnt_op    = CNT_HOLD;
    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (any_low) begin
            lat_col_d = first_col;
            if (NEED == 1) begin
              code_d  = {row_q, first_col};
              valid_d = 1'b1;
              held_d  = 1'b1;
              state_d = ST_HELD;
            end else begin
              state_d = ST_CONFIRM;
              cnt_op  = CNT_ONE;
            end
          end else begin
            row_adv = 1'b1;
          end
        end
        ST_CONFIRM: begin
          if (col_low[lat_col_q]) begin
            if (cnt_q == LAST_CNT) begin
              code_d  = {row_q, lat_col_q};
              valid_d = 1'b1;
              held_d  = 1'b1;
              state_d = ST_HELD;
              cnt_op  = CNT_CLR;
            end else begin
              cnt_op  = CNT_INC;
            end
          end else begin
            state_d = ST_SCAN;
            cnt_op  = CNT_CLR;
            row_adv = 1'b1;
          end
        end
        ST_HELD: begin
          if (!col_low[lat_col_q]) begin
            if (NEED == 1) begin
              held_d  = 1'b0;
              state_d = ST_SCAN;
              row_adv = 1'b1;
            end else begin
              state_d = ST_RELEASE;
              cnt_op  = CNT_ONE;
            end
          end
        end
        ST_RELEASE: begin
          if (!col_low[lat_col_q]) begin
            if (cnt_q == LAST_CNT) begin
              held_d  = 1'b0;
              state_d = ST_SCAN;
              cnt_op  = CNT_CLR;
              row_adv = 1'b1;
            end else begin
              cnt_op  = CNT_INC;
            end
          end else begin
            state_d = ST_HELD;
            cnt_op  = CNT_CLR;
          end
        end
        default: begin
          state_d = ST_SCAN;
          cnt_op  = CNT_CLR;
        end
      endcase
    end
  end

  // FSM, row index and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_SCAN;
      row_q     <= '0;
      lat_col_q <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_adv ? row_q + ROW_W'(1) : row_q;
      lat_col_q <= lat_col_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
    end
  end

  assign Row_Out   = ~(ROWS'(1) << row_q);
  assign Key_Code  = code_q;
  assign Key_Valid = valid_q;
  assign Key_Held  = held_q;

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 1000; CLK cycles per row dwell (min 2).
REQ-002 Parameter DEBOUNCE_SCANS, default 4; full 4-row rotations a key must be stable (min 1).
REQ-003 CLK  input  1  system clock; all logic on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 Col_In  input  4  keypad column lines, active-low, pulled up externally, asynchronous to CLK.
REQ-006 Row_Out  output  4  row drive, active-low, exactly one row low at a time.
REQ-007 Key_Code  output  4  code of last accepted key, row*4+col.
REQ-008 Key_Valid  output  1  one-cycle pulse when a new key is accepted.
REQ-009 Key_Held  output  1  high while the accepted key remains pressed.

Function
REQ-010 Col_In SHALL pass through a 2-flop synchronizer before any use.
REQ-011 A divider SHALL generate a scan tick every SCAN_DIV cycles; each tick advances row index 0->1->2->3->0.
REQ-012 Row_Out SHALL be ~(4'b0001 << row index); columns SHALL be sampled on the cycle before the tick.
REQ-013 FSM states: SCAN, CONFIRM, HELD, RELEASE.
REQ-014 SCAN: first sample with any column low SHALL latch row and lowest-index low column, go to CONFIRM, and freeze row advance on that row.
REQ-015 CONFIRM: each sample at tick SHALL increment a stable count if the same column is still low, else return to SCAN with the count cleared and row advance resumed.
REQ-016 CONFIRM: count reaching DEBOUNCE_SCANS*4 samples SHALL update Key_Code, pulse Key_Valid for exactly one cycle, set Key_Held, and go to HELD.
REQ-017 HELD: row stays frozen; a sample with latched column high SHALL go to RELEASE.
REQ-018 RELEASE: latched column high for DEBOUNCE_SCANS*4 consecutive samples SHALL clear Key_Held and go to SCAN; a low sample in RELEASE SHALL return to HELD without a new Key_Valid.
REQ-019 Second key pressed while HELD SHALL be ignored until release completes.
REQ-020 Multiple columns low in one row: lowest index wins; other rows are not examined while frozen.
REQ-021 Key_Code SHALL hold its value between accepts; it changes only with Key_Valid.

Reset
REQ-022 RST SHALL set Row_Out=4'b1110, row index 0, divider 0, FSM SCAN, counters 0, Key_Code 0, Key_Valid 0, Key_Held 0, synchronizer flops 1.
REQ-023 RST asserted mid-CONFIRM or HELD SHALL abort without a Key_Valid pulse.

Configuration
REQ-024 Macro KEYPAD_DEBOUNCE_EN: when defined, REQ-015/016/018 apply as written.
REQ-025 Without KEYPAD_DEBOUNCE_EN: CONFIRM is bypassed, Key_Valid fires on the first detecting sample, release needs one high sample; DEBOUNCE_SCANS is ignored.

Structure
REQ-026 Shared package keypad_pkg SHALL hold the FSM state encoding, row/column width constants (4) and key-code width.
REQ-027 One sub-module key_sync_debounce SHALL contain the synchronizer and stable counter; divider and FSM stay in keypad_scan.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=2, macro defined unless stated)
REQ-028 After RST: Row_Out=1110, rotates 1101,1011,0111 every 4 cycles; Key_Valid never pulses with Col_In=1111.
REQ-029 Hold col 2 low only while row 1 driven, stable -> exactly one Key_Valid, Key_Code=6, Key_Held=1; release -> Key_Held=0 after 8 high samples.
REQ-030 Col 0 bounces (low 3 samples, high 1) on row 3 -> no Key_Valid; then stable -> Key_Code=12 once.
REQ-031 Cols 1 and 3 low together on row 2 -> Key_Code=9.
REQ-032 RST pulsed during CONFIRM -> no Key_Valid, outputs at reset values next cycle.
REQ-033 Macro undefined: key 15 (row 3, col 3) -> Key_Valid on first detecting sample, Key_Code=15.
